// File: rtl/mem_ctrl.sv
// mem_ctrl: initiator-side access controller for a single-port synchronous
// 64x16 memory. Takes one read or write request at a time from the core over
// a valid/ready handshake. It drives the memory we/addr/data pins, waits out
// the memory read latency, and returns a one-cycle response pulse.
//
// Optional feature: define MEM_CTRL_READBACK_EN to add a VERIFY state. In that
// mode every write is read back and compared against the written data, and a
// mismatch is reported on rsp_err. When the macro is undefined, rsp_err is
// tied to 0.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready   request handshake; accepted when both are high at an edge
//   req_we, req_addr,       request: 1 = write / 0 = read, word address,
//   req_wdata               write data
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata               read data; updated only on read completion
//   rsp_err                 readback mismatch flag, valid with rsp_valid
//   mem_we, mem_addr,       memory write enable, address, write data
//   mem_data
//   mem_out                 memory read data, RD_LAT cycles after the address is presented
module mem_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_out
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("mem_ctrl: RD_LAT must be in 1..4");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
`ifdef MEM_CTRL_READBACK_EN
    VERIFY = 3'd3,
`endif
    DONE   = 3'd4
  } state_t;

  // Count value on whose closing edge the memory data is valid.
  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_t              state_q;
  logic [2:0]          lat_cnt_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_data_q;
`ifdef MEM_CTRL_READBACK_EN
  logic                rsp_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
`ifdef MEM_CTRL_READBACK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      // rsp_valid is a single-cycle pulse; only the completing states raise it.
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // req_ready comes up one cycle after reset release, then stays up in IDLE.
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            mem_we_q    <= req_we;
            mem_addr_q  <= req_addr;
            mem_data_q  <= req_wdata;
            lat_cnt_q   <= '0;
            state_q     <= req_we ? WRITE : READ;
          end
        end
        WRITE: begin
          // The memory commits at this closing edge; the enable is for one cycle only.
          mem_we_q <= 1'b0;
`ifdef MEM_CTRL_READBACK_EN
          lat_cnt_q <= '0;
          state_q   <= VERIFY;
`else
          rsp_valid_q <= 1'b1;
          state_q     <= DONE;
`endif
        end
        READ: begin
          if (lat_cnt_q == LAT_LAST) begin
            rsp_rdata_q <= mem_out;
            rsp_valid_q <= 1'b1;
`ifdef MEM_CTRL_READBACK_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= DONE;
          end else begin
            lat_cnt_q <= lat_cnt_q + 3'd1;
          end
        end
`ifdef MEM_CTRL_READBACK_EN
        VERIFY: begin
          // Readback of the address just written; rsp_rdata is deliberately untouched.
          if (lat_cnt_q == LAT_LAST) begin
            rsp_err_q   <= (mem_out != mem_data_q);
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            lat_cnt_q <= lat_cnt_q + 3'd1;
          end
        end
`endif
        DONE: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
`ifdef MEM_CTRL_READBACK_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl. Two instances are used: index 0 has RD_LAT=1 and
// index 1 has RD_LAT=4. Each instance has its own synchronous memory model.
module tb_mem_ctrl;

`ifdef MEM_CTRL_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic clk;
  logic rst_n;
  logic [1:0]       rv, rwe, rdy, rspv, rerr, mwe, stuck;
  logic [1:0][5:0]  ra, madr;
  logic [1:0][15:0] rwd, rrd, mdat, mout;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 4;
    localparam int PI  = (LAT == 1) ? 1 : LAT - 1;
    logic [15:0] mem [64];
    logic [15:0] pipe [1:3];
    logic [15:0] cur;

    initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
      mem[3]  = 16'h0007;
      mem[16] = 16'hBEEF;
    end

    // Read data for the presented address, with an optional bit0 stuck-at-0 fault.
    always_comb cur = mem[madr[g]] & (stuck[g] ? 16'hFFFE : 16'hFFFF);

    always @(posedge clk) begin
      if (mwe[g]) mem[madr[g]] <= mdat[g];
      pipe[1] <= cur;
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
    end

    assign mout[g] = (LAT == 1) ? cur : pipe[PI];

    mem_ctrl #(.ADDR_W(6), .DATA_W(16), .RD_LAT(LAT)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (rv[g]),
      .req_ready (rdy[g]),
      .req_we    (rwe[g]),
      .req_addr  (ra[g]),
      .req_wdata (rwd[g]),
      .rsp_valid (rspv[g]),
      .rsp_rdata (rrd[g]),
      .rsp_err   (rerr[g]),
      .mem_we    (mwe[g]),
      .mem_addr  (madr[g]),
      .mem_data  (mdat[g]),
      .mem_out   (mout[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one request on instance d and check the complete transaction.
  // exp_n is the number of negedges from the first negedge after acceptance
  // up to the rsp_valid cycle.
  task automatic do_req(input int d, input logic we, input logic [5:0] a,
                        input logic [15:0] wd, input logic [15:0] exp_rd,
                        input logic exp_err, input int exp_n, input string nm);
    int n, we_cyc, rdy_hi;
    @(negedge clk);
    chk({nm, " ready_before"}, rdy[d], 1);
    rv[d] = 1'b1; rwe[d] = we; ra[d] = a; rwd[d] = wd;
    @(negedge clk);
    // Scramble the request inputs to show that the latched copy is used.
    rv[d] = 1'b0; rwe[d] = ~we; ra[d] = ~a; rwd[d] = ~wd;
    n = 1; we_cyc = 0; rdy_hi = 0;
    while (!rspv[d] && n < 20) begin
      we_cyc += int'(mwe[d]);
      rdy_hi += int'(rdy[d]);
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, exp_n);
    chk({nm, " ready_busy"}, rdy_hi + int'(rdy[d]), 0);
    chk({nm, " mem_we_cycles"}, we_cyc + int'(mwe[d]), we ? 1 : 0);
    chk({nm, " rdata"}, rrd[d], exp_rd);
    chk({nm, " err"}, rerr[d], exp_err);
    chk({nm, " mem_addr"}, madr[d], a);
    if (we) chk({nm, " mem_data"}, mdat[d], wd);
    @(negedge clk);
    chk({nm, " pulse_end"}, rspv[d], 0);
    chk({nm, " ready_after"}, rdy[d], 1);
    chk({nm, " rdata_hold"}, rrd[d], exp_rd);
  endtask

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tv[6];

  initial begin
    int n, wc;
    logic seen;

    tv[0] = '{1'b0, 6'd3,  16'h0000, 16'h0007, 1'b0};
    tv[1] = '{1'b1, 6'd3,  16'h0005, 16'h0007, 1'b0};
    tv[2] = '{1'b0, 6'd3,  16'h0000, 16'h0005, 1'b0};
    tv[3] = '{1'b1, 6'h2A, 16'hA5A5, 16'h0005, 1'b0};
    tv[4] = '{1'b0, 6'h2A, 16'h0000, 16'hA5A5, 1'b0};
    tv[5] = '{1'b0, 6'h10, 16'h0000, 16'hBEEF, 1'b0};

    rst_n = 1'b0; rv = '0; rwe = '0; ra = '0; rwd = '0; stuck = '0;

    // Reset state and release
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst req_ready", rdy[d], 0);
      chk("rst rsp_valid", rspv[d], 0);
      chk("rst rsp_rdata", rrd[d], 0);
      chk("rst rsp_err", rerr[d], 0);
      chk("rst mem_we", mwe[d], 0);
      chk("rst mem_addr", madr[d], 0);
      chk("rst mem_data", mdat[d], 0);
    end
    rst_n = 1'b1;
    #1 chk("release ready_immediate", rdy[0], 0);
    @(negedge clk);
    chk("release ready0", rdy[0], 1);
    chk("release ready1", rdy[1], 1);

    // Table-driven transactions on the RD_LAT=1 instance
    for (int i = 0; i < 6; i++)
      do_req(0, tv[i].we, tv[i].addr, tv[i].wdata, tv[i].exp_rd, tv[i].exp_err,
             tv[i].we ? 2 + RB : 2, $sformatf("vec%0d", i));

    // Back-to-back writes with req_valid held
    @(negedge clk);
    rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 6'h3F; rwd[0] = 16'hFFFF;
    n = 0; wc = 0;
    while (!rspv[0] && n < 20) begin
      @(negedge clk); n++; wc += int'(mwe[0]);
    end
    chk("b2b first_pulse", rspv[0], 1);
    ra[0] = 6'h00; rwd[0] = 16'h1234;
    n = 0;
    do begin
      @(negedge clk); n++; wc += int'(mwe[0]);
    end while (!rspv[0] && n < 20);
    rv[0] = 1'b0;
    chk("b2b pulse_spacing", n, 3 + RB);
    chk("b2b mem_we_cycles", wc, 2);
    chk("b2b rdata_unchanged", rrd[0], 16'hBEEF);
    do_req(0, 1'b0, 6'h3F, 16'h0, 16'hFFFF, 1'b0, 2, "b2b rd_top");
    do_req(0, 1'b0, 6'h00, 16'h0, 16'h1234, 1'b0, 2, "b2b rd_zero");

    // Reset during a READ on the RD_LAT=4 instance
    do_req(1, 1'b0, 6'd3, 16'h0, 16'h0007, 1'b0, 5, "lat4 rd");
    @(negedge clk);
    rv[1] = 1'b1; rwe[1] = 1'b0; ra[1] = 6'd3;
    @(negedge clk);
    rv[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst ready", rdy[1], 0);
    chk("midrst rsp_valid", rspv[1], 0);
    chk("midrst mem_we", mwe[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk); seen |= rspv[1];
    end
    chk("midrst no_response", seen, 0);
    chk("midrst ready_after", rdy[1], 1);
    chk("midrst rdata_cleared", rrd[1], 0);
    do_req(1, 1'b0, 6'd3, 16'h0, 16'h0007, 1'b0, 5, "midrst next_rd");

    // Readback with a stuck-at-0 bit0 in the memory (rsp_rdata was cleared by reset)
    stuck[0] = 1'b1;
    do_req(0, 1'b1, 6'd5, 16'h0001, 16'h0000, (RB == 1) ? 1'b1 : 1'b0, 2 + RB, "rb w1");
    do_req(0, 1'b1, 6'd6, 16'h0002, 16'h0000, 1'b0, 2 + RB, "rb w2");
    stuck[0] = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
